// File: rtl/bit_rate_meter.sv
// Throughput monitor: counts data_valid_i beats over a fixed window of
// CLK_MHZ_VAL*WINDOW_US cycles and reports beats*DATA_WIDTH, saturating.
module bit_rate_meter #(
  parameter int CLK_MHZ_VAL = 100,
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW_US   = 1000000
) (
  input  logic        clk_i,
  input  logic        s_rst_n_i,
  input  logic        data_valid_i,
  output logic [31:0] bit_rate_o
);

  localparam int          RES_WIDTH = 32;
  localparam longint      WIN_CYC   = longint'(CLK_MHZ_VAL) * longint'(WINDOW_US);
  localparam int          CNT_RAW   = $clog2(WIN_CYC + 64'd1);
  localparam int          CNT_W     = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [63:0] SAT_LIM   = {{(64-RES_WIDTH){1'b0}}, {RES_WIDTH{1'b1}}};

  if (CLK_MHZ_VAL < 1 || DATA_WIDTH < 1 || WINDOW_US < 1) begin : g_bad_param
    $error("bit_rate_meter: all parameters must be >= 1");
  end

  logic [CNT_W-1:0]     r_win_cnt;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [RES_WIDTH-1:0] r_bit_rate;

  logic                 w_last;
  logic [63:0]          w_total;
  logic [63:0]          w_prod;
  logic [RES_WIDTH-1:0] w_sat;

  assign w_last  = (r_win_cnt == CNT_W'(WIN_CYC - 64'd1));
  // A beat on the closing cycle still belongs to the window being closed.
  assign w_total = 64'(r_beat_cnt) + 64'(data_valid_i);
  assign w_prod  = w_total * 64'(DATA_WIDTH);

  // Clamp the 64-bit product to the output range.
  always_comb begin
    w_sat = {RES_WIDTH{1'b1}};
    if (w_prod > SAT_LIM) begin
      w_sat = {RES_WIDTH{1'b1}};
    end else begin
      w_sat = w_prod[RES_WIDTH-1:0];
    end
  end

  // Window and beat counters; result register updates only at window end.
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      r_win_cnt  <= {CNT_W{1'b0}};
      r_beat_cnt <= {CNT_W{1'b0}};
      r_bit_rate <= {RES_WIDTH{1'b0}};
    end else if (w_last) begin
      r_win_cnt  <= {CNT_W{1'b0}};
      r_beat_cnt <= {CNT_W{1'b0}};
      r_bit_rate <= w_sat;
    end else begin
      r_win_cnt  <= r_win_cnt + CNT_W'(1);
      r_beat_cnt <= r_beat_cnt + CNT_W'(data_valid_i);
      r_bit_rate <= r_bit_rate;
    end
  end

  assign bit_rate_o = r_bit_rate;

endmodule

// File: tb/tb_bit_rate_meter.sv
// Directed bench: two meters (DATA_WIDTH 32 and 50e6) with a 100-cycle window
// share one stimulus stream; expected values are hand-computed per window.
module tb_bit_rate_meter;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] rate_m;
  logic [31:0] rate_s;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_m;
  logic [31:0] exp_s;

  bit_rate_meter #(.CLK_MHZ_VAL(100), .DATA_WIDTH(32), .WINDOW_US(1)) dut (
    .clk_i       (clk),
    .s_rst_n_i   (rst_n),
    .data_valid_i(valid),
    .bit_rate_o  (rate_m)
  );

  bit_rate_meter #(.CLK_MHZ_VAL(100), .DATA_WIDTH(50000000), .WINDOW_US(1)) dut_sat (
    .clk_i       (clk),
    .s_rst_n_i   (rst_n),
    .data_valid_i(valid),
    .bit_rate_o  (rate_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic v);
    valid = v;
    @(posedge clk);
    #1;
  endtask

  // One 100-cycle window. mode: 0 idle, 1 all valid, 2 toggle, 3 pulse@99, 4 pulse@0.
  task automatic win(input string tag, input int mode, input logic [31:0] nm, input logic [31:0] ns);
    logic v;
    for (int c = 0; c < 100; c++) begin
      case (mode)
        1:       v = 1'b1;
        2:       v = (c % 2 == 0);
        3:       v = (c == 99);
        4:       v = (c == 0);
        default: v = 1'b0;
      endcase
      cyc(v);
      if (c == 99) begin
        exp_m = nm;
        exp_s = ns;
      end
      chk({tag, "_m"}, rate_m, exp_m);
      chk({tag, "_s"}, rate_s, exp_s);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_m       = 32'd0;
    exp_s       = 32'd0;
    rst_n       = 1'b0;
    valid       = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      chk("reset_m", rate_m, 32'd0);
      chk("reset_s", rate_s, 32'd0);
    end
    rst_n = 1'b1;

    win("idle_first", 0, 32'd0,    32'd0);
    win("full",       1, 32'd3200, 32'd4294967295);
    win("toggle",     2, 32'd1600, 32'd2500000000);
    win("idle",       0, 32'd0,    32'd0);
    win("pulse99",    3, 32'd32,   32'd50000000);
    win("pulse0",     4, 32'd32,   32'd50000000);
    win("idle2",      0, 32'd0,    32'd0);
    win("full2",      1, 32'd3200, 32'd4294967295);

    for (int i = 0; i < 60; i++) begin
      cyc(1'b1);
      chk("partial_m", rate_m, 32'd3200);
      chk("partial_s", rate_s, 32'd4294967295);
    end
    rst_n = 1'b0;
    cyc(1'b1);
    exp_m = 32'd0;
    exp_s = 32'd0;
    chk("midrst_m", rate_m, 32'd0);
    chk("midrst_s", rate_s, 32'd0);
    rst_n = 1'b1;
    win("after_rst", 1, 32'd3200, 32'd4294967295);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
